// File: rtl/rdft_seq_ctrl.sv
// Frame sequencer for the RDFT loader / transform processor pair: load N samples, start, wait, drain N bins.
// Optional watchdog on the COMPUTE wait is enabled by defining RDFT_WDOG_EN (adds the wd_err output).
module rdft_seq_ctrl #(
    parameter int N        = 8,
    parameter int LOG2N    = 3,
    parameter int MAX_WAIT = 64,
    parameter int FCW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ld_en,
    output logic [LOG2N-1:0] ld_addr,
    output logic             tp_start,
    input  logic             tp_done,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [LOG2N-1:0] o_idx,
    output logic             o_last,
    output logic             busy,
    output logic [FCW-1:0]   frame_cnt
`ifdef RDFT_WDOG_EN
    ,
    output logic             wd_err
`endif
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] PENULT   = LOG2N'(N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [LOG2N-1:0] r_addr;
    logic [LOG2N-1:0] r_idx;
    logic             r_tp_start;
    logic             r_o_valid;
    logic             r_o_last;
    logic             r_busy;
    logic [FCW-1:0]   r_frame_cnt;

    logic w_accept;
    logic w_xfer;
    logic w_wd_expire;

    assign s_ready   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign ld_en     = s_valid & s_ready;
    assign ld_addr   = r_addr;
    assign tp_start  = r_tp_start;
    assign o_valid   = r_o_valid;
    assign o_idx     = r_idx;
    assign o_last    = r_o_last;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

    assign w_accept = ld_en;
    assign w_xfer   = r_o_valid & o_ready;

`ifdef RDFT_WDOG_EN
    localparam int WDW = $clog2(MAX_WAIT + 1);

    logic [WDW-1:0] r_wd_cnt;
    logic           r_wd_err;

    // Counter sits at zero outside COMPUTE, so every COMPUTE visit starts from a clean count.
    assign w_wd_expire = (r_wd_cnt == WDW'(MAX_WAIT - 1));
    assign wd_err      = r_wd_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else begin
            if (r_state != S_COMPUTE) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (r_state == S_COMPUTE && !tp_done && w_wd_expire) begin
                r_wd_err <= 1'b1;
            end
        end
    end
`else
    // Constant false: without the watchdog COMPUTE waits indefinitely.
    assign w_wd_expire = (MAX_WAIT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_idx       <= '0;
            r_tp_start  <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_last    <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_tp_start <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (r_addr == LAST_IDX) begin
                            r_addr     <= '0;
                            r_state    <= S_START;
                            r_tp_start <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_START: begin
                    r_state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    // tp_done takes priority over a watchdog expiry on the same cycle.
                    if (tp_done) begin
                        r_state   <= S_DRAIN;
                        r_o_valid <= 1'b1;
                        r_idx     <= '0;
                        r_o_last  <= 1'b0;
                    end else if (w_wd_expire) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_xfer) begin
                        if (r_o_last) begin
                            r_state     <= S_IDLE;
                            r_o_valid   <= 1'b0;
                            r_o_last    <= 1'b0;
                            r_busy      <= 1'b0;
                            r_idx       <= '0;
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            r_o_last <= (r_idx == PENULT);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rdft_seq_ctrl.sv
// Directed bench for rdft_seq_ctrl (N=8, FCW=2, MAX_WAIT=16); watchdog cases run when RDFT_WDOG_EN is defined.
module tb_rdft_seq_ctrl;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int MW    = 16;
    localparam int FCW   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic             ld_en;
    logic [LOG2N-1:0] ld_addr;
    logic             tp_start;
    logic             tp_done;
    logic             o_valid;
    logic             o_ready;
    logic [LOG2N-1:0] o_idx;
    logic             o_last;
    logic             busy;
    logic [FCW-1:0]   frame_cnt;
`ifdef RDFT_WDOG_EN
    logic             wd_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int fc_exp  = 0;

    rdft_seq_ctrl #(.N(N), .LOG2N(LOG2N), .MAX_WAIT(MW), .FCW(FCW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .tp_start  (tp_start),
        .tp_done   (tp_done),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_idx     (o_idx),
        .o_last    (o_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
`ifdef RDFT_WDOG_EN
        ,
        .wd_err    (wd_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Loads one frame, with an idle cycle before addresses gap_a and gap_b (-1 = none).
    // Returns positioned at the negedge of the START cycle.
    task automatic load_frame(input int gap_a, input int gap_b);
        int pulses = 0;
        for (int a = 0; a < N; a++) begin
            if (a == gap_a || a == gap_b) begin
                @(negedge clk);
                s_valid = 1'b0;
                #1;
                chk("gap_ld_en", ld_en, 0);
                chk("gap_addr", ld_addr, a);
            end
            @(negedge clk);
            s_valid = 1'b1;
            #1;
            chk("ld_addr", ld_addr, a);
            chk("ld_en", ld_en, 1);
            if (ld_en) pulses++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("tp_start_pulse", tp_start, 1);
        chk("s_ready_after_load", s_ready, 0);
        chk("ld_en_after_load", ld_en, 0);
        chk("ld_pulses", pulses, N);
    endtask

    // From the START negedge: optional tp_done during START (must be ignored), then tp_done
    // asserted done_delay cycles after the START cycle. Returns at the first DRAIN negedge.
    task automatic compute(input int done_delay, input bit done_at_start);
        tp_done = done_at_start;
        for (int d = 1; d < done_delay; d++) begin
            @(negedge clk);
            tp_done = 1'b0;
            chk("tp_start_once", tp_start, 0);
            chk("compute_no_valid", o_valid, 0);
            chk("compute_busy", busy, 1);
        end
        @(negedge clk);
        tp_done = 1'b1;
        @(negedge clk);
        tp_done = 1'b0;
    endtask

    task automatic drain(input bit toggle);
        int e = 0;
        int cyc = 0;
        while (e < N && cyc < 4 * N) begin
            chk("o_valid", o_valid, 1);
            chk("o_idx", o_idx, e);
            chk("o_last", o_last, (e == N - 1) ? 1 : 0);
            o_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (o_ready) e++;
            cyc++;
            @(negedge clk);
        end
        if (e < N) chk("drain_timeout", e, N);
        o_ready = 1'b0;
        fc_exp = (fc_exp + 1) % (1 << FCW);
        chk("busy_after_drain", busy, 0);
        chk("o_valid_after_drain", o_valid, 0);
        chk("o_last_after_drain", o_last, 0);
        chk("frame_cnt", frame_cnt, fc_exp);
    endtask

    task automatic check_reset_state();
        chk("rst_busy", busy, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_tp_start", tp_start, 0);
        chk("rst_ld_addr", ld_addr, 0);
        chk("rst_o_idx", o_idx, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_s_ready", s_ready, 1);
`ifdef RDFT_WDOG_EN
        chk("rst_wd_err", wd_err, 0);
`endif
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        tp_done = 1'b0;
        o_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Frame 1: back-to-back load, tp_done during START ignored, done 10 cycles later, toggling ready.
        load_frame(-1, -1);
        compute(10, 1'b1);
        drain(1'b1);

        // Frame 2: stalls before addresses 2 and 5.
        load_frame(2, 5);
        compute(3, 1'b0);
        drain(1'b0);

        // Frames 3..5 exercise frame counter wrap (3, 0, 1).
        for (int f = 0; f < 3; f++) begin
            load_frame(-1, -1);
            compute(2, 1'b0);
            drain(f[0]);
        end

        // Spurious tp_done in IDLE.
        @(negedge clk);
        tp_done = 1'b1;
        @(negedge clk);
        tp_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_valid", o_valid, 0);
        chk("idle_done_s_ready", s_ready, 1);

        // Partial load with tp_done in LOAD, then reset at address 4.
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            s_valid = 1'b1;
            tp_done = (a == 2);
            #1;
            chk("part_addr", ld_addr, a);
        end
        @(negedge clk);
        s_valid = 1'b0;
        tp_done = 1'b0;
        chk("part_addr4", ld_addr, 4);
        chk("part_busy", busy, 1);
        chk("part_no_valid", o_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fc_exp = 0;
        check_reset_state();

        // Next frame after the abort starts cleanly at address 0.
        load_frame(-1, -1);
        compute(4, 1'b0);
        drain(1'b0);

`ifdef RDFT_WDOG_EN
        // Withheld tp_done: 16 COMPUTE cycles, then IDLE with wd_err and unchanged count.
        load_frame(-1, -1);
        for (int k = 0; k < MW; k++) begin
            @(negedge clk);
            chk("wd_busy", busy, 1);
        end
        @(negedge clk);
        chk("wd_idle", busy, 0);
        chk("wd_err_set", wd_err, 1);
        chk("wd_frame_cnt", frame_cnt, fc_exp);
        chk("wd_no_valid", o_valid, 0);
        load_frame(-1, -1);
        compute(5, 1'b0);
        drain(1'b0);
        chk("wd_err_sticky", wd_err, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rdft_seq_ctrl.md
Name: rdft_seq_ctrl

Overview:
- Frame sequencer for the RDFT datapath (loader/reorder stage followed by transform processor).
- Accepts N complex samples per frame from upstream over a valid/ready handshake and generates loader write enables and addresses.
- Pulses the transform start, waits for transform completion, then drains N output bins downstream over a valid/ready handshake.
- Control only. Sample data (real and j parts, `bits+1 wide, signed) bypasses this block.

Parameters:
- N, 8, points per frame; must be a power of two, at least 2.
- LOG2N, 3, log2(N); width of the address and index ports.
- MAX_WAIT, 64, watchdog limit in cycles for COMPUTE (used only when RDFT_WDOG_EN is defined).
- FCW, 8, width of the frame counter.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  upstream sample valid
- s_ready  out  1  controller can accept a sample
- ld_en  out  1  loader write enable, equal to s_valid & s_ready
- ld_addr  out  LOG2N  loader write index for the current sample
- tp_start  out  1  one-cycle start pulse to the transform processor
- tp_done  in  1  one-cycle completion pulse from the transform processor
- o_valid  out  1  output bin available
- o_ready  in  1  downstream accepts the bin
- o_idx  out  LOG2N  index of the bin being presented
- o_last  out  1  high with the bin where o_idx = N-1
- busy  out  1  high in any state except IDLE
- frame_cnt  out  FCW  count of completed frames; wraps modulo 2^FCW

Behaviour:
- Reset: rst is sampled on a clk edge only. On reset:
  - state = IDLE; ld_addr = 0, o_idx = 0, frame_cnt = 0.
  - tp_start = 0, o_valid = 0, o_last = 0, busy = 0.
  - Watchdog counter = 0, wd_err = 0.
  - Reset asserted mid-frame aborts the frame. Partially loaded samples are discarded and the next frame starts at address 0.
- State encoding: IDLE, LOAD, START, COMPUTE, DRAIN.
- s_ready is 1 in IDLE and LOAD, otherwise 0. ld_en and ld_addr are combinational from the registered state and address.
- IDLE:
  - On s_valid, accept the sample at address 0; next state LOAD, ld_addr becomes 1.
  - Without s_valid, remain in IDLE.
- LOAD:
  - Each accepted sample writes at ld_addr, then ld_addr increments.
  - s_valid low inserts a stall; the address holds.
  - Acceptance at ld_addr = N-1 moves to START, and ld_addr wraps to 0.
- START: tp_start = 1 for exactly one cycle, then COMPUTE.
- COMPUTE:
  - Wait for tp_done, then go to DRAIN with o_idx = 0.
  - tp_done in any other state is ignored.
  - tp_done coincident with the START cycle is ignored.
- DRAIN:
  - o_valid = 1. o_idx and o_last are stable while o_ready = 0.
  - o_valid & o_ready advances o_idx.
  - A transfer with o_last set returns to IDLE next cycle, clears o_valid and increments frame_cnt (2^FCW-1 wraps to 0).
- Frame latency: the first upstream beat to tp_start is N cycles with no stalls. tp_done to the first o_valid is 1 cycle.
- There is no overlap between frames. A new frame is accepted only after the last bin of the previous frame has been transferred.

Optional Feature:
- Macro: RDFT_WDOG_EN.
- When defined:
  - A counter runs in COMPUTE, cleared on entering COMPUTE.
  - If it reaches MAX_WAIT with no tp_done, the controller moves to IDLE, sets sticky output wd_err (1 bit, added after frame_cnt), and does not increment frame_cnt.
  - wd_err is cleared only by rst.
  - tp_done on the same cycle the counter reaches MAX_WAIT wins; the frame drains normally.
- When not defined: no counter and no wd_err port. COMPUTE waits indefinitely.

Test Plan:
- Reset, then N=8 back-to-back valid samples → ld_addr 0..7 with ld_en on 8 consecutive cycles; tp_start pulses once, 1 cycle after the 8th sample; s_ready = 0 afterwards.
- Inject s_valid gaps at addresses 2 and 5 → addresses never skip or repeat; exactly 8 ld_en pulses; tp_start only after address 7.
- tp_done 10 cycles after tp_start; o_ready toggling 1,0,1,0 → o_idx 0..7 each held while o_ready = 0; o_last only at 7; frame_cnt goes 0→1; busy drops the cycle after the last transfer.
- Spurious tp_done in IDLE and LOAD, plus rst asserted at ld_addr = 4 → no state change from tp_done; after rst, all outputs at reset values and the next frame loads from address 0.
- FCW=2, run 5 frames → frame_cnt sequence 1,2,3,0,1.
- With RDFT_WDOG_EN and MAX_WAIT=16, withhold tp_done → IDLE after 16 COMPUTE cycles, wd_err = 1, frame_cnt unchanged, next frame still completes.
